// File: rtl/painterengine_gpu_pkg.sv
// Shared types for the GPU reader scheduler: FSM states and reader error codes.
// Lanes are 32-bit slices of the 128-bit per-requester buses.
package painterengine_gpu_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_REPORT,
        ST_DRAIN
    } sched_state_e;

    typedef enum logic [2:0] {
        ERR_OK        = 3'b000,
        ERR_ROUTER    = 3'b001,
        ERR_ADDRESS   = 3'b010,
        ERR_ADDR_TOUT = 3'b011,
        ERR_DATA_TOUT = 3'b100,
        ERR_PROTOCOL  = 3'b101,
        ERR_ABORT     = 3'b110
    } reader_err_e;

    function automatic logic [LANE_W-1:0] lane_pick(
        input logic [LANES*LANE_W-1:0] bus,
        input logic [1:0]              idx
    );
        return bus[{idx, 5'b0} +: LANE_W];
    endfunction

    function automatic logic [LANES*LANE_W-1:0] lane_place(
        input logic [LANE_W-1:0] val,
        input logic [1:0]        idx
    );
        return {96'b0, val} << {idx, 5'b0};
    endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter4.sv
// Four-way round-robin pick: first set request strictly after the pointer,
// ascending with wrap; the pointer's own slot has lowest priority.
module painterengine_gpu_rr_arbiter4
    import painterengine_gpu_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                grant = 4'b0001 << cand;
                idx   = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/painterengine_gpu_reader_scheduler.sv
// Shares the one-shot GPU DMA reader between four requesters, re-arming the
// reader through its reset for every job and reporting done/error per lane.
module painterengine_gpu_reader_scheduler
    import painterengine_gpu_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2,
    parameter logic [2:0]  ABORT_CODE   = ERR_ABORT
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_resetn,
    input  logic [3:0]   i_wire_req,
    input  logic [127:0] i_wire_req_address,
    input  logic [127:0] i_wire_req_length,
    input  logic         i_wire_abort,
    output logic [3:0]   o_wire_grant,
    output logic [3:0]   o_wire_req_done,
    output logic [3:0]   o_wire_req_error,
    output logic [2:0]   o_wire_error_type,
    output logic         o_wire_busy,
    output logic         o_wire_reader_resetn,
    output logic [3:0]   o_wire_reader_router,
    output logic [127:0] o_wire_reader_address,
    output logic [127:0] o_wire_reader_length,
    input  logic         i_wire_reader_done,
    input  logic         i_wire_reader_error,
    input  logic [2:0]   i_wire_reader_error_type
);

    sched_state_e state, state_n;
    logic [3:0]   cnt, cnt_n;
    logic [1:0]   ptr, ptr_n;
    logic [1:0]   idx, idx_n;
    logic [3:0]   grant, grant_n;
    logic [3:0]   done, done_n;
    logic [3:0]   err, err_n;
    logic [2:0]   etype, etype_n;
    logic         busy, busy_n;
    logic         rrst, rrst_n;
    logic [3:0]   router, router_n;
    logic [127:0] addr, addr_n;
    logic [127:0] len, len_n;

    logic [3:0]   arb_grant;
    logic [1:0]   arb_idx;
    logic         arb_any;

    painterengine_gpu_rr_arbiter4 u_arb (
        .req   (i_wire_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ptr    <= 2'd3;
            idx    <= '0;
            grant  <= '0;
            done   <= '0;
            err    <= '0;
            etype  <= '0;
            busy   <= 1'b0;
            rrst   <= 1'b0;
            router <= '0;
            addr   <= '0;
            len    <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ptr    <= ptr_n;
            idx    <= idx_n;
            grant  <= grant_n;
            done   <= done_n;
            err    <= err_n;
            etype  <= etype_n;
            busy   <= busy_n;
            rrst   <= rrst_n;
            router <= router_n;
            addr   <= addr_n;
            len    <= len_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ptr_n    = ptr;
        idx_n    = idx;
        grant_n  = grant;
        done_n   = '0;
        err_n    = '0;
        etype_n  = etype;
        rrst_n   = rrst;
        router_n = router;
        addr_n   = addr;
        len_n    = len;
        case (state)
            ST_IDLE: begin
                rrst_n   = 1'b0;
                router_n = '0;
                if (arb_any) begin
                    grant_n  = arb_grant;
                    router_n = arb_grant;
                    idx_n    = arb_idx;
                    addr_n   = lane_place(lane_pick(i_wire_req_address, arb_idx), arb_idx);
                    len_n    = lane_place(lane_pick(i_wire_req_length, arb_idx), arb_idx);
                    cnt_n    = 4'(RESET_CYCLES);
                    state_n  = ST_ARM;
                end
            end
            ST_ARM: begin
                if (i_wire_abort) begin
                    err_n   = grant;
                    etype_n = ABORT_CODE;
                    rrst_n  = 1'b0;
                    state_n = ST_REPORT;
                end else if (cnt <= 4'd1) begin
                    // Router and lanes were set a cycle earlier, so they are
                    // stable before the reader leaves reset.
                    rrst_n  = 1'b1;
                    state_n = ST_RUN;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_RUN: begin
                if (i_wire_abort) begin
                    err_n   = grant;
                    etype_n = ABORT_CODE;
                    rrst_n  = 1'b0;
                    state_n = ST_REPORT;
                end else if (i_wire_reader_error) begin
                    err_n   = grant;
                    etype_n = i_wire_reader_error_type;
                    rrst_n  = 1'b0;
                    state_n = ST_REPORT;
                end else if (i_wire_reader_done) begin
                    done_n  = grant;
                    rrst_n  = 1'b0;
                    state_n = ST_REPORT;
                end
            end
            ST_REPORT: begin
                rrst_n   = 1'b0;
                grant_n  = '0;
                router_n = '0;
                addr_n   = '0;
                len_n    = '0;
                ptr_n    = idx;
                state_n  = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    assign o_wire_grant          = grant;
    assign o_wire_req_done       = done;
    assign o_wire_req_error      = err;
    assign o_wire_error_type     = etype;
    assign o_wire_busy           = busy;
    assign o_wire_reader_resetn  = rrst;
    assign o_wire_reader_router  = router;
    assign o_wire_reader_address = addr;
    assign o_wire_reader_length  = len;

endmodule
